// File: rtl/sd_pkg.sv
`default_nettype none
// sd_pkg: shared types, frame lengths and CRC7 step for the SD command engine.
// Revision: 1.0
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TX   = 3'd1,
      ST_WAIT = 3'd2,
      ST_RX   = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      RESP_NONE        = 2'b00,
      RESP_SHORT       = 2'b01,
      RESP_LONG        = 2'b10,
      RESP_SHORT_NOCRC = 2'b11
   } resp_t;

   localparam int CMD_LEN  = 48;
   localparam int LONG_LEN = 136;

   // One serial step of CRC7, generator x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc7_serial.sv
`default_nettype none
// crc7_serial: bit-serial CRC7 accumulator with synchronous clear (clear wins over enable).
// Revision: 1.0
module crc7_serial
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         crc <= '0;
      end else if (enable) begin
         crc <= crc7_step(crc, bit_in);
      end
   end

endmodule
`default_nettype wire

// File: rtl/sd_cmd_engine.sv
`default_nettype none
// sd_cmd_engine: SD card CMD-line engine - sends a 48-bit command, collects the response, checks CRC7.
// Revision: 1.0
module sd_cmd_engine
   import sd_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int NCR_MAX = 64,
   parameter int NRC_GAP = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic [5:0]   i_cmd_idx,
   input  logic [31:0]  i_arg,
   input  logic [1:0]   i_resp_type,
   output logic         o_busy,
   output logic         o_done,
   output logic [2:0]   o_status,
   output logic [127:0] o_resp,
   output logic [5:0]   o_resp_idx,
   output logic         o_sd_clk,
   input  logic         i_sd_cmd,
   output logic         o_sd_cmd,
   output logic         o_sd_cmd_oe
);

   localparam int             DW             = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST       = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0]  DIV_HALF       = DW'(CLK_DIV / 2);
   localparam logic [15:0]    NCR_LAST       = 16'(NCR_MAX - 1);
   localparam logic [15:0]    GAP_LAST       = 16'(NRC_GAP - 1);
   localparam logic [7:0]     TX_END         = 8'(CMD_LEN);
   localparam logic [7:0]     TX_CRC_POS     = 8'(CMD_LEN - 8);
   localparam logic [7:0]     SHORT_LAST     = 8'(CMD_LEN - 2);
   localparam logic [7:0]     LONG_LAST      = 8'(LONG_LEN - 2);
   localparam logic [7:0]     SHORT_CRC_END  = 8'(CMD_LEN - 9);
   localparam logic [7:0]     LONG_CRC_BEGIN = 8'd7;
   localparam logic [7:0]     LONG_CRC_END   = 8'(LONG_LEN - 9);

   state_t               state;
   resp_t                resp_type;
   logic [DW-1:0]        div_cnt;
   logic [7:0]           bit_cnt;
   logic [15:0]          tmr;
   logic [CMD_LEN-1:0]   tx_sr;
   logic [126:0]         rx_sr;
   logic [127:0]         rx_next;
   logic [7:0]           rx_last;
   logic                 rx_crc_bit;
   logic                 rise, fall;
   logic                 crc_clear, crc_en, crc_bit;
   logic [6:0]           crc;

   always_ff @(posedge clk) begin
      if (!rst)                    div_cnt <= '0;
      else if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                          div_cnt <= div_cnt + 1'b1;
   end

   assign rise     = (div_cnt == DIV_HALF);
   assign fall     = (div_cnt == '0);
   assign o_sd_clk = (div_cnt >= DIV_HALF);

   // Response frame position of the current bit is bit_cnt+1 (start bit already seen in WAIT).
   assign rx_next    = {rx_sr, i_sd_cmd};
   assign rx_last    = (resp_type == RESP_LONG) ? LONG_LAST : SHORT_LAST;
   assign rx_crc_bit = (resp_type == RESP_LONG) ? (bit_cnt >= LONG_CRC_BEGIN && bit_cnt < LONG_CRC_END)
                                                : (bit_cnt < SHORT_CRC_END);

   assign crc_clear = (state == ST_IDLE && i_start) || (state == ST_TX && fall && bit_cnt == TX_END);
   assign crc_en    = (state == ST_TX && fall && bit_cnt < TX_CRC_POS) ||
                      (state == ST_RX && rise && rx_crc_bit);
   assign crc_bit   = (state == ST_TX) ? tx_sr[CMD_LEN-1] : i_sd_cmd;

   crc7_serial u_crc (
      .clk    (clk),
      .rst    (rst),
      .clear  (crc_clear),
      .enable (crc_en),
      .bit_in (crc_bit),
      .crc    (crc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         resp_type   <= RESP_NONE;
         bit_cnt     <= '0;
         tmr         <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_status    <= '0;
         o_resp      <= '0;
         o_resp_idx  <= '0;
         o_sd_cmd    <= 1'b1;
         o_sd_cmd_oe <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  tx_sr      <= {2'b01, i_cmd_idx, i_arg, 8'h00};
                  resp_type  <= resp_t'(i_resp_type);
                  o_busy     <= 1'b1;
                  o_status   <= '0;
                  o_resp     <= '0;
                  o_resp_idx <= '0;
                  bit_cnt    <= '0;
                  state      <= ST_TX;
               end
            end
            ST_TX: begin
               if (fall) begin
                  if (bit_cnt == TX_END) begin
                     o_sd_cmd_oe <= 1'b0;
                     o_sd_cmd    <= 1'b1;
                     bit_cnt     <= '0;
                     tmr         <= '0;
                     state       <= (resp_type == RESP_NONE) ? ST_GAP : ST_WAIT;
                  end else begin
                     o_sd_cmd_oe <= 1'b1;
                     bit_cnt     <= bit_cnt + 8'd1;
                     // CRC is final once the 40 covered bits are out; splice it plus the end bit in.
                     if (bit_cnt == TX_CRC_POS) begin
                        o_sd_cmd <= crc[6];
                        tx_sr    <= {crc[5:0], 1'b1, {(CMD_LEN-7){1'b0}}};
                     end else begin
                        o_sd_cmd <= tx_sr[CMD_LEN-1];
                        tx_sr    <= {tx_sr[CMD_LEN-2:0], 1'b0};
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (rise) begin
                  if (!i_sd_cmd) begin
                     bit_cnt <= '0;
                     state   <= ST_RX;
                  end else if (tmr == NCR_LAST) begin
                     o_status[0] <= 1'b1;
                     tmr         <= '0;
                     state       <= ST_GAP;
                  end else begin
                     tmr <= tmr + 16'd1;
                  end
               end
            end
            ST_RX: begin
               if (rise) begin
                  rx_sr <= rx_next[126:0];
                  if (bit_cnt == rx_last) begin
                     o_status[2] <= (resp_type != RESP_SHORT_NOCRC) && (crc != rx_sr[6:0]);
                     o_status[1] <= !i_sd_cmd;
                     if (resp_type == RESP_LONG) begin
                        o_resp     <= rx_next;
                        o_resp_idx <= '0;
                     end else begin
                        o_resp     <= {96'd0, rx_next[39:8]};
                        o_resp_idx <= rx_next[45:40];
                     end
                     tmr   <= '0;
                     state <= ST_GAP;
                  end else begin
                     bit_cnt <= bit_cnt + 8'd1;
                  end
               end
            end
            ST_GAP: begin
               o_sd_cmd    <= 1'b1;
               o_sd_cmd_oe <= 1'b0;
               if (rise) begin
                  if (tmr == GAP_LAST) begin
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= ST_IDLE;
                  end else begin
                     tmr <= tmr + 16'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/sd_cmd_engine.md
SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SD clock period (even, >= 2).
REQ-002 SHALL have parameter NCR_MAX, default 64, meaning the maximum number of SD clocks to wait for a response start bit.
REQ-003 SHALL have parameter NRC_GAP, default 8, meaning the number of idle SD clocks driven after each transaction.
REQ-004 SHALL have port clk  in  1  system clock; the block uses one clock only.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port i_start  in  1  one-cycle command request.
REQ-007 SHALL have port i_cmd_idx  in  6  command index.
REQ-008 SHALL have port i_arg  in  32  command argument.
REQ-009 SHALL have port i_resp_type  in  2  response type: 00 none, 01 short (48 bit) with CRC, 10 long (136 bit) with CRC, 11 short without CRC check.
REQ-010 SHALL have port o_busy  out  1  high from the accepted start until done.
REQ-011 SHALL have port o_done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port o_status  out  3  {crc_err, end_err, timeout}, valid while o_done is high and held afterwards.
REQ-013 SHALL have port o_resp  out  128  response payload; short responses use [31:0] for bits 39:8 and zero the upper bits; long responses use bits 127:0.
REQ-014 SHALL have port o_resp_idx  out  6  short-response index field.
REQ-015 SHALL have port o_sd_clk  out  1  generated SD clock.
REQ-016 SHALL have port i_sd_cmd  in  1  CMD line input.
REQ-017 SHALL have port o_sd_cmd  out  1  CMD line output.
REQ-018 SHALL have port o_sd_cmd_oe  out  1  CMD line output enable.

Function
REQ-019 Divider SHALL run freely: counter 0..CLK_DIV-1; o_sd_clk is high when counter >= CLK_DIV/2.
REQ-020 The rise strobe SHALL be the cycle in which the counter equals CLK_DIV/2; the fall strobe SHALL be the cycle in which the counter equals 0.
REQ-021 The FSM SHALL have states IDLE, TX, WAIT, RX, GAP.
REQ-022 IDLE: i_start SHALL latch the index, argument and type, set o_busy the next cycle and go to TX; i_start outside IDLE SHALL be ignored.
REQ-023 TX SHALL drive 48 bits MSB first, changing o_sd_cmd on fall strobes only: 0, 1, idx[5:0], arg[31:0], CRC7, 1, with o_sd_cmd_oe high.
REQ-024 In TX, CRC7 (polynomial x^7+x^3+1, initial value 0) SHALL be computed serially over the first 40 bits as they shift out.
REQ-025 After the end bit, TX SHALL go to GAP if i_resp_type is 00, otherwise to WAIT; o_sd_cmd_oe SHALL drop at the first fall strobe after the end bit.
REQ-026 WAIT SHALL sample i_sd_cmd on rise strobes; a 0 SHALL enter RX.
REQ-027 If NCR_MAX rise strobes pass with no start bit, WAIT SHALL set timeout and go to GAP.
REQ-028 RX SHALL sample on rise strobes the remaining 47 bits (short) or 135 bits (long).
REQ-029 The short-response CRC SHALL cover bits 47..8 and be compared against bits 7..1.
REQ-030 The long-response CRC SHALL cover the 120 bits that follow the 8-bit header and be compared against bits 7..1.
REQ-031 A CRC mismatch SHALL set crc_err; type 11 SHALL never set crc_err.
REQ-032 A last bit of 0 SHALL set end_err.
REQ-033 GAP SHALL hold o_sd_cmd high and o_sd_cmd_oe low for NRC_GAP rise strobes.
REQ-034 At the end of GAP the block SHALL pulse o_done, clear o_busy in the same cycle and return to IDLE.
REQ-035 On accept, o_status SHALL clear to 0.
REQ-036 o_resp and o_resp_idx SHALL hold their values from RX until the next accepted start.
REQ-037 Bit counters SHALL be 8 bits wide and SHALL NOT wrap; the maximum count is 135.

Reset
REQ-038 While rst is low at a clk edge: state IDLE, divider counter 0, o_busy 0, o_done 0, o_status 0, o_resp 0, o_resp_idx 0, o_sd_cmd 1, o_sd_cmd_oe 0, o_sd_clk 0.
REQ-039 A reset during any state, including mid-TX, SHALL abort the transaction with no o_done pulse.

Structure
REQ-040 A shared package sd_pkg SHALL hold the state enum, the response-type enum, and the constants CMD_LEN=48 and LONG_LEN=136.
REQ-041 The serial CRC7 SHALL be a sub-module crc7_serial (ports: clear, enable, bit in, 7-bit crc out), instantiated once and reused by TX and RX.

Verification
REQ-042 Bench SHALL cover: CMD0, arg 0, type 00 -> line carries 0x400000000095, no oe after the end bit, o_done with status 000.
REQ-043 Bench SHALL cover: CMD8, arg 0x1AA, type 01 -> TX 0x48000001AA87; card model replies 0x08000001AA13 -> o_resp_idx 8, o_resp[31:0] 0x000001AA, status 000.
REQ-044 Bench SHALL cover: type 01 with a silent card -> timeout after NCR_MAX rise strobes, status 001, o_done one cycle.
REQ-045 Bench SHALL cover: short reply with one CRC bit flipped -> status 100; the same reply with type 11 -> status 000.
REQ-046 Bench SHALL cover: type 10 with a 136-bit CID carrying a valid CRC -> o_resp equals the model CID; end bit forced to 0 -> status 010.
REQ-047 Bench SHALL cover: rst low at TX bit 20 -> outputs at reset values, no o_done; a new i_start one cycle after reset release is accepted normally.
